lfsr_seq_gen: RTL

//  Parametrised successor to the lab switch-seeded 10-bit shift sequencer: a WIDTH-bit

---
 rtl/lfsr_seq_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/lfsr_seq_gen.sv
// Seed-loadable WIDTH-bit pattern generator: Fibonacci/Galois LFSR, rotate-left or hold,
// with a step counter and wrap-to-seed pulse. Define LFSR_LOCKUP_RECOVER_EN to reseed on lock-up.
module lfsr_seq_gen #(
    parameter int              WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = 10'h240,
    parameter logic [WIDTH-1:0] GTAPS = 10'h009,
    parameter logic [WIDTH-1:0] SEED  = 10'h001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);

    typedef enum logic [1:0] {
        MODE_FIB    = 2'b00,
        MODE_GALOIS = 2'b01,
        MODE_ROT    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pd_q, pd_d;
    logic [WIDTH-1:0] nx;
    logic             advance;
    logic             lfsr_mode;

    assign advance   = en && (mode_e'(mode) != MODE_HOLD);
    assign lfsr_mode = ~mode[1];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        nx     = q_q;
        q_d    = q_q;
        seed_d = seed_q;
        cnt_d  = cnt_q;
        pd_d   = 1'b0;

        case (mode_e'(mode))
            MODE_FIB:    nx = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
            MODE_GALOIS: nx = {q_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q_q[WIDTH-1]}} & GTAPS);
            MODE_ROT:    nx = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            default:     nx = q_q;
        endcase

        if (load) begin
            q_d    = seed_in;
            seed_d = seed_in;
            cnt_d  = '0;
        end else if (advance) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (lfsr_mode && (q_q == '0)) begin
                // Escape the all-zero trap by restarting the sequence from the reset seed.
                q_d    = SEED;
                seed_d = SEED;
                cnt_d  = '0;
            end else begin
                q_d   = nx;
                cnt_d = cnt_q + 1'b1;
                pd_d  = (nx == seed_q);
            end
`else
            q_d   = nx;
            cnt_d = cnt_q + 1'b1;
            pd_d  = (nx == seed_q);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= SEED;
            seed_q <= SEED;
            cnt_q  <= '0;
            pd_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            q_q    <= q_d;
            seed_q <= seed_d;
            cnt_q  <= cnt_d;
            pd_q   <= pd_d;
        end
    end

    assign q           = q_q;
    assign serial_out  = q_q[WIDTH-1];
    assign step_cnt    = cnt_q;
    assign period_done = pd_q;
    assign lockup      = lfsr_mode && (q_q == '0);

endmodule
